// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-controlled register bank with core-side arbitration.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [5:0] FC_CLEAR   = 6'h00;
  localparam logic [5:0] FC_LOCK    = 6'h01;
  localparam logic [5:0] FC_UNLOCK  = 6'h02;
  localparam logic [5:0] FC_CLRSTAT = 6'h3F;

  localparam int STAT_LOCK   = 7;
  localparam int STAT_PEND   = 6;
  localparam int STAT_OVF    = 5;
  localparam int STAT_CNT_HI = 4;
  localparam int STAT_CNT_LO = 0;

  localparam int             COLL_W   = 5;
  localparam logic [COLL_W-1:0] COLL_MAX = 5'd31;

endpackage

// File: rtl/spi_regbank_array.sv
// Register storage with an SPI write port, a core write port and a bulk clear.
// Priority per register: SPI write, then clear, then core write.
module spi_regbank_array #(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            clear,
  input  logic                            spi_we,
  input  logic [ADDR_W-1:0]               spi_addr,
  input  logic [REG_W-1:0]                spi_wdata,
  input  logic                            core_we,
  input  logic [ADDR_W-1:0]               core_addr,
  input  logic [REG_W-1:0]                core_wdata,
  input  logic [ADDR_W-1:0]               rd_addr_a,
  output logic [REG_W-1:0]                rd_data_a,
  input  logic [ADDR_W-1:0]               rd_addr_b,
  output logic [REG_W-1:0]                rd_data_b,
  output logic [(1<<ADDR_W)*REG_W-1:0]    regs_flat
);

  localparam int NREG = 1 << ADDR_W;

  logic [REG_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (spi_we && spi_addr == ADDR_W'(k))
          regs[k] <= spi_wdata;
        else if (clear)
          regs[k] <= '0;
        else if (core_we && core_addr == ADDR_W'(k))
          regs[k] <= core_wdata;
      end
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NREG; k++) regs_flat[k*REG_W +: REG_W] = regs[k];
  end

endmodule

// File: rtl/spi_regbank_arb.sv
// Register bank shared between an SPI host (always wins) and a core requester
// arbitrated by an IDLE/GRANT/RELEASE handshake, plus fast commands and status.
module spi_regbank_arb
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int REG_W  = 8
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic [ADDR_W-1:0]               spi_addr,
  input  logic [REG_W-1:0]                spi_wdata,
  input  logic                            spi_wvld,
  input  logic [5:0]                      fastcmd,
  input  logic                            fastcmd_vld,
  output logic [REG_W-1:0]                spi_rdata,
  output logic [7:0]                      status,
  input  logic                            core_req,
  input  logic                            core_we,
  input  logic [ADDR_W-1:0]               core_addr,
  input  logic [REG_W-1:0]                core_wdata,
  output logic                            core_gnt,
  output logic [REG_W-1:0]                core_rdata,
  output logic                            core_err,
  output logic [(1<<ADDR_W)*REG_W-1:0]    regs_flat
);

  arb_state_e state, state_nxt;

  logic              lock;
  logic              ovf;
  logic [COLL_W-1:0] coll_cnt;
  logic [7:0]        status_nxt;

  logic fc_clear, fc_lock, fc_unlock, fc_clrstat, fc_unknown;
  logic go_grant, collision, core_wr, gnt_nxt, err_nxt;
  logic [REG_W-1:0] core_rd;

  always_comb begin
    fc_clear   = 1'b0;
    fc_lock    = 1'b0;
    fc_unlock  = 1'b0;
    fc_clrstat = 1'b0;
    fc_unknown = 1'b0;
    if (fastcmd_vld) begin
      case (fastcmd)
        FC_CLEAR:   fc_clear   = 1'b1;
        FC_LOCK:    fc_lock    = 1'b1;
        FC_UNLOCK:  fc_unlock  = 1'b1;
        FC_CLRSTAT: fc_clrstat = 1'b1;
        default:    fc_unknown = 1'b1;
      endcase
    end
  end

  // Any SPI activity in the same cycle keeps the core waiting in IDLE.
  assign go_grant = core_req && !spi_wvld && !fastcmd_vld;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (go_grant) state_nxt = ST_GRANT;
      ST_GRANT:   state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Grant/err are computed on IDLE exit so they line up with the GRANT cycle;
  // the core write itself is decided during GRANT against live SPI/fastcmd activity.
  always_comb begin
    gnt_nxt   = 1'b0;
    err_nxt   = 1'b0;
    collision = 1'b0;
    core_wr   = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_nxt = go_grant;
        err_nxt = go_grant && core_we && lock;
      end
      ST_GRANT: begin
        collision = core_we && spi_wvld && (spi_addr == core_addr);
        core_wr   = core_we && !lock && !collision && !fc_clear;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      core_gnt   <= 1'b0;
      core_err   <= 1'b0;
      core_rdata <= '0;
    end else begin
      core_gnt <= gnt_nxt;
      core_err <= err_nxt;
      if (gnt_nxt) core_rdata <= core_rd;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lock     <= 1'b0;
      ovf      <= 1'b0;
      coll_cnt <= '0;
    end else begin
      if (fc_lock)        lock <= 1'b1;
      else if (fc_unlock) lock <= 1'b0;
      if (fc_clrstat) begin
        coll_cnt <= '0;
        ovf      <= 1'b0;
      end else begin
        if (collision) begin
          if (coll_cnt == COLL_MAX) ovf <= 1'b1;
          else                      coll_cnt <= coll_cnt + 5'd1;
        end
        if (fc_unknown) ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    status_nxt                           = '0;
    status_nxt[STAT_LOCK]                = lock;
    status_nxt[STAT_PEND]                = (state == ST_IDLE) && core_req;
    status_nxt[STAT_OVF]                 = ovf;
    status_nxt[STAT_CNT_HI:STAT_CNT_LO]  = coll_cnt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) status <= '0;
    else       status <= status_nxt;
  end

  spi_regbank_array #(
    .ADDR_W (ADDR_W),
    .REG_W  (REG_W)
  ) u_array (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (fc_clear),
    .spi_we     (spi_wvld),
    .spi_addr   (spi_addr),
    .spi_wdata  (spi_wdata),
    .core_we    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .rd_addr_a  (spi_addr),
    .rd_data_a  (spi_rdata),
    .rd_addr_b  (core_addr),
    .rd_data_b  (core_rd),
    .regs_flat  (regs_flat)
  );

endmodule

// File: tb/tb_spi_regbank_arb.sv
// Scoreboard bench for spi_regbank_arb: grant results queued at request time,
// popped when core_gnt appears; register/status model tracked alongside.
module tb_spi_regbank_arb;
  import spi_reg_pkg::*;

  localparam int ADDR_W = 3;
  localparam int REG_W  = 8;
  localparam int NREG   = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic [ADDR_W-1:0] spi_addr;
  logic [REG_W-1:0]  spi_wdata;
  logic              spi_wvld;
  logic [5:0]        fastcmd;
  logic              fastcmd_vld;
  logic [REG_W-1:0]  spi_rdata;
  logic [7:0]        status;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [REG_W-1:0]  core_wdata;
  logic              core_gnt;
  logic [REG_W-1:0]  core_rdata;
  logic              core_err;
  logic [NREG*REG_W-1:0] regs_flat;

  spi_regbank_arb #(.ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .spi_wvld    (spi_wvld),
    .fastcmd     (fastcmd),
    .fastcmd_vld (fastcmd_vld),
    .spi_rdata   (spi_rdata),
    .status      (status),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rdata  (core_rdata),
    .core_err    (core_err),
    .regs_flat   (regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             err;
    logic [REG_W-1:0] rdata;
  } exp_t;

  exp_t             sb [$];
  logic [REG_W-1:0] model [NREG];
  logic             m_lock;
  logic             m_ovf;
  logic [4:0]       m_cnt;
  int               tests_run = 0;
  int               tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    for (int k = 0; k < NREG; k++) model[k] = '0;
    m_lock = 1'b0;
    m_ovf  = 1'b0;
    m_cnt  = '0;
  endtask

  function automatic logic [NREG*REG_W-1:0] modelFlat();
    logic [NREG*REG_W-1:0] f;
    for (int k = 0; k < NREG; k++) f[k*REG_W +: REG_W] = model[k];
    return f;
  endfunction

  function automatic logic [7:0] expStatus();
    return {m_lock, 1'b0, m_ovf, m_cnt};
  endfunction

  task automatic applyFcModel(input logic [5:0] code);
    case (code)
      6'h00:   for (int k = 0; k < NREG; k++) model[k] = '0;
      6'h01:   m_lock = 1'b1;
      6'h02:   m_lock = 1'b0;
      6'h3F:   begin m_cnt = '0; m_ovf = 1'b0; end
      default: m_ovf = 1'b1;
    endcase
  endtask

  // Waits (bounded) for a grant, checks its latency, then pops and compares.
  task automatic waitGrant(input string tag, output logic seen);
    exp_t e;
    int   waited;
    seen   = 1'b0;
    waited = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      waited = c + 1;
      if (core_gnt) seen = 1'b1;
    end
    checkOutput({tag, "_gnt_within_2"}, (seen && waited <= 2), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        checkOutput({tag, "_err"}, core_err, e.err);
        checkOutput({tag, "_rdata"}, core_rdata, e.rdata);
      end
    end
  endtask

  task automatic sendFastcmd(input logic [5:0] code);
    fastcmd     = code;
    fastcmd_vld = 1'b1;
    @(negedge clk);
    fastcmd_vld = 1'b0;
    applyFcModel(code);
    @(negedge clk);
    checkOutput("fc_status", status, expStatus());
  endtask

  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr, input logic [REG_W-1:0] wdata,
                               input logic spi_en, input logic [ADDR_W-1:0] spi_a, input logic [REG_W-1:0] spi_d,
                               input logic fc_en, input logic [5:0] fc_code);
    exp_t e;
    logic seen;
    logic coll;
    core_req   = 1'b1;
    core_we    = we;
    core_addr  = addr;
    core_wdata = wdata;
    e.err   = we && m_lock;
    e.rdata = model[addr];
    sb.push_back(e);
    waitGrant("xact", seen);
    if (seen) begin
      if (spi_en) begin
        spi_wvld  = 1'b1;
        spi_addr  = spi_a;
        spi_wdata = spi_d;
      end
      if (fc_en) begin
        fastcmd_vld = 1'b1;
        fastcmd     = fc_code;
      end
      coll = we && spi_en && (spi_a == addr);
      for (int k = 0; k < NREG; k++) begin
        if (spi_en && spi_a == ADDR_W'(k))                        model[k] = spi_d;
        else if (fc_en && fc_code == 6'h00)                       model[k] = '0;
        else if (we && !m_lock && !coll && addr == ADDR_W'(k))    model[k] = wdata;
      end
      if (coll) begin
        if (m_cnt == 5'd31) m_ovf = 1'b1;
        else                m_cnt = m_cnt + 5'd1;
      end
      if (fc_en) applyFcModel(fc_code);
    end
    @(negedge clk);
    core_req    = 1'b0;
    core_we     = 1'b0;
    spi_wvld    = 1'b0;
    fastcmd_vld = 1'b0;
    checkOutput("release_gnt", core_gnt, 0);
    checkOutput("release_err", core_err, 0);
    @(negedge clk);
    checkOutput("xact_flat", regs_flat, modelFlat());
    checkOutput("xact_status", status, expStatus());
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic seen;
    nrst = 1'b0;
    spi_addr = '0; spi_wdata = '0; spi_wvld = 1'b0;
    fastcmd = '0; fastcmd_vld = 1'b0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("rst_gnt", core_gnt, 0);
    checkOutput("rst_err", core_err, 0);
    checkOutput("rst_rdata", core_rdata, 0);
    checkOutput("rst_status", status, 0);
    checkOutput("rst_flat", regs_flat, 0);
    nrst = 1'b1;
    @(negedge clk);

    applyStimulus(1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 6'h00);
    checkOutput("wr_reg3", regs_flat[31:24], 8'hA5);
    spi_addr = 3'd3;
    #1 checkOutput("spi_rdata3", spi_rdata, 8'hA5);
    applyStimulus(1'b0, 3'd3, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 6'h00);

    applyStimulus(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 6'h00);
    checkOutput("coll_reg2", regs_flat[23:16], 8'h22);
    checkOutput("coll_cnt", status[4:0], 5'd1);

    applyStimulus(1'b1, 3'd4, 8'h44, 1'b1, 3'd5, 8'h55, 1'b0, 6'h00);
    checkOutput("dual_reg4", regs_flat[39:32], 8'h44);
    checkOutput("dual_reg5", regs_flat[47:40], 8'h55);

    sendFastcmd(FC_LOCK);
    checkOutput("lock_bit", status[7], 1);
    applyStimulus(1'b1, 3'd1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, 6'h00);
    checkOutput("lock_reg1", regs_flat[15:8], 8'h00);
    sendFastcmd(FC_UNLOCK);
    applyStimulus(1'b1, 3'd1, 8'hFF, 1'b0, 3'd0, 8'h00, 1'b0, 6'h00);
    checkOutput("unlock_reg1", regs_flat[15:8], 8'hFF);

    sendFastcmd(6'h15);
    checkOutput("unknown_ovf", status[5], 1);
    sendFastcmd(FC_CLRSTAT);
    checkOutput("clrstat1", status[5:0], 6'd0);

    for (int i = 0; i < 33; i++)
      applyStimulus(1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0, 6'h00);
    checkOutput("sat_cnt", status[4:0], 5'd31);
    checkOutput("sat_ovf", status[5], 1);
    sendFastcmd(FC_CLRSTAT);
    checkOutput("clrstat2", status[5:0], 6'd0);

    applyStimulus(1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b1, FC_CLEAR);
    checkOutput("clear_flat", regs_flat, 0);

    // SPI writes held for four cycles keep the pending core request waiting.
    core_req = 1'b1; core_we = 1'b0; core_addr = 3'd7;
    spi_wvld = 1'b1; spi_addr = 3'd7; spi_wdata = 8'h77;
    model[7] = 8'h77;
    e.err = 1'b0; e.rdata = 8'h77;
    sb.push_back(e);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("blk_nognt", core_gnt, 0);
      if (c == 1) checkOutput("blk_pend", status[6], 1);
    end
    spi_wvld = 1'b0;
    waitGrant("blk", seen);
    @(negedge clk);
    core_req = 1'b0;
    @(negedge clk);
    checkOutput("blk_flat", regs_flat, modelFlat());

    // Reset during GRANT must abort the pending write.
    core_req = 1'b1; core_we = 1'b1; core_addr = 3'd0; core_wdata = 8'h5A;
    e.err = m_lock; e.rdata = model[0];
    sb.push_back(e);
    waitGrant("rstg", seen);
    #1 nrst = 1'b0;
    #1;
    resetModel();
    checkOutput("rstg_gnt", core_gnt, 0);
    checkOutput("rstg_err", core_err, 0);
    checkOutput("rstg_rdata", core_rdata, 0);
    checkOutput("rstg_status", status, 0);
    checkOutput("rstg_flat", regs_flat, 0);
    core_req = 1'b0; core_we = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rstg_reg0", regs_flat[7:0], 8'h00);
    checkOutput("rstg_flat_after", regs_flat, modelFlat());

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
